kosei_i2s_rx: RTL

Parametrised stereo I2S/left-justified serial audio receiver for the Kosei M1 audio path. It replaces the single-bit capture stage with full-word deserialisation: `DATA_W`-bit, MSB-first, left-aligned words. It synchronises to word-select, detects malformed frames, and presents complete stereo frames on a valid/ready interface with overrun accounting. It sits between the I2S pins and the downstream volume/DAC pipeline, entirely in the `i2s_bclk` domain.

---
 rtl/kosei_i2s_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kosei_i2s_rx.sv
// Kosei M1 stereo I2S / left-justified receiver.
// Deserialises L/R words and presents frames on a valid/ready port.
module kosei_i2s_rx #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 8
) (
  input  logic              i2s_bclk,
  input  logic              rst_n,
  input  logic              i2s_lrclk,
  input  logic              i2s_data,
  input  logic              fmt_i2s,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              frame_err,
  output logic              overrun,
  output logic              overrun_flag,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              locked
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] FULL = BW'(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  state_t state, state_nxt;

  logic              ws_d, ws_dd;
  logic              ws_eff, ws_prev;
  logic              slot_start;
  logic              slot_full;
  logic              word_done;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-2:0] sr;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] left_hold;
  logic              err_nxt;
  logic              hold_en;
  logic              load_try;
  logic              load;
  logic              drop;

  // I2S delays the data by one bclk, so compare the delayed WS pair
  assign ws_eff     = fmt_i2s ? ws_d  : i2s_lrclk;
  assign ws_prev    = fmt_i2s ? ws_dd : ws_d;
  assign slot_start = ws_eff != ws_prev;
  assign slot_full  = bit_cnt == FULL;
  assign word_done  = !slot_start && (bit_cnt == LAST);
  assign word       = {sr, i2s_data};

  assign load = load_try && (!out_valid || out_ready);
  assign drop = load_try && !load;

  assign locked = state != SYNC;

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    hold_en   = 1'b0;
    load_try  = 1'b0;
    unique case (state)
      SYNC: begin
        if (slot_start && !ws_eff) state_nxt = LEFT;
      end
      LEFT: begin
        hold_en = word_done;
        if (slot_start && ws_eff) begin
          if (slot_full) begin
            state_nxt = RIGHT;
          end else begin
            state_nxt = SYNC;
            err_nxt   = 1'b1;
          end
        end
      end
      RIGHT: begin
        load_try = word_done;
        if (slot_start && !ws_eff) begin
          state_nxt = LEFT;
          err_nxt   = !slot_full;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge i2s_bclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      ws_d      <= 1'b0;
      ws_dd     <= 1'b0;
      bit_cnt   <= '0;
      sr        <= '0;
      left_hold <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ws_d      <= i2s_lrclk;
      ws_dd     <= ws_d;
      frame_err <= err_nxt;
      overrun   <= drop;
      if (slot_start) begin
        bit_cnt <= BW'(1);
        sr      <= word[DATA_W-2:0];
      end else if (bit_cnt < FULL) begin
        bit_cnt <= bit_cnt + BW'(1);
        sr      <= word[DATA_W-2:0];
      end
      if (hold_en) left_hold <= word;
    end
  end

  always_ff @(posedge i2s_bclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_left     <= '0;
      out_right    <= '0;
      frame_cnt    <= '0;
      overrun_flag <= 1'b0;
    end else begin
      if (load) begin
        out_left  <= left_hold;
        out_right <= word;
        out_valid <= 1'b1;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // a new drop outranks a clear on the same edge
      if (drop) begin
        overrun_flag <= 1'b1;
      end else if (err_clr) begin
        overrun_flag <= 1'b0;
      end
    end
  end

endmodule
